// File: rtl/btn_conditioner_if.sv
// Button bundle between the raw push-button pins, the conditioner and the cursor stage.
// The master drives the raw pins. The slave (btn_conditioner) drives the pulses and levels.
interface btn_conditioner_if;
  logic       in_btn_up;
  logic       in_btn_down;
  logic       in_btn_left;
  logic       in_btn_right;
  logic       in_selected;
  logic       out_btn_up;
  logic       out_btn_down;
  logic       out_btn_left;
  logic       out_btn_right;
  logic       out_selected;
  logic [4:0] btn_level;

  modport master (
    output in_btn_up, in_btn_down, in_btn_left, in_btn_right, in_selected,
    input  out_btn_up, out_btn_down, out_btn_left, out_btn_right, out_selected, btn_level
  );

  modport slave (
    input  in_btn_up, in_btn_down, in_btn_left, in_btn_right, in_selected,
    output out_btn_up, out_btn_down, out_btn_left, out_btn_right, out_selected, btn_level
  );
endinterface

// File: rtl/btn_conditioner.sv
// Five-channel push-button conditioner: 2-flop synchronizer, debounce, single-cycle press pulses.
// Define BTN_AUTOREPEAT_EN to add auto-repeat pulses on the four direction channels while held.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 7500000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  btn_conditioner_if.slave bus
);
  localparam int unsigned    NCH     = 5;
  localparam int unsigned    DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned   SEL_CH      = 4;
  localparam int unsigned   RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned   RW          = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;
`else
  typedef enum logic {IDLE, PRESSED} state_t;
`endif

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1_q, sync2_q;
  logic [NCH-1:0] level_q, level_d;
  logic [NCH-1:0] pulse_q, pulse_d;

  // Polarity is folded in ahead of the first flop so cleared synchronizer flops read as "released".
  assign raw = {bus.in_selected, bus.in_btn_right, bus.in_btn_left, bus.in_btn_down, bus.in_btn_up}
               ^ {NCH{ACTIVE_LOW}};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           toggle, rise, fall, rpt_pulse;
    state_t         state_q, state_d;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit CAN_REPEAT = (ch != SEL_CH);
    logic [RW-1:0] rpt_q, rpt_d;
`endif

    always_comb begin
      db_cnt_d = '0;
      toggle   = 1'b0;
      if (sync2_q[ch] != level_q[ch]) begin
        if (db_cnt_q == DB_LAST) toggle = 1'b1;
        else                     db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    assign rise        = toggle & ~level_q[ch];
    assign fall        = toggle &  level_q[ch];
    assign level_d[ch] = level_q[ch] ^ toggle;
    assign pulse_d[ch] = rise | rpt_pulse;

    always_comb begin
      state_d   = state_q;
      rpt_pulse = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_d     = rpt_q;
`endif
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = PRESSED;
`ifdef BTN_AUTOREPEAT_EN
            rpt_d   = '0;
`endif
          end
        end
        PRESSED: begin
`ifdef BTN_AUTOREPEAT_EN
          if (CAN_REPEAT && rpt_q == DELAY_LAST) begin
            state_d   = REPEAT;
            rpt_d     = '0;
            rpt_pulse = 1'b1;
          end else if (rpt_q != '1) begin
            rpt_d = rpt_q + 1'b1;
          end
`endif
        end
`ifdef BTN_AUTOREPEAT_EN
        REPEAT: begin
          if (rpt_q == PERIOD_LAST) begin
            rpt_d     = '0;
            rpt_pulse = 1'b1;
          end else if (rpt_q != '1) begin
            rpt_d = rpt_q + 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
      // A release overrides any repeat pulse due on the same edge.
      if (fall) begin
        state_d   = IDLE;
        rpt_pulse = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_d     = '0;
`endif
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt_q <= '0;
        state_q  <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
        rpt_q    <= '0;
`endif
      end else begin
        db_cnt_q <= db_cnt_d;
        state_q  <= state_d;
`ifdef BTN_AUTOREPEAT_EN
        rpt_q    <= rpt_d;
`endif
      end
    end
  end

  assign bus.out_btn_up    = pulse_q[0];
  assign bus.out_btn_down  = pulse_q[1];
  assign bus.out_btn_left  = pulse_q[2];
  assign bus.out_btn_right = pulse_q[3];
  assign bus.out_selected  = pulse_q[4];
  assign bus.btn_level     = level_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus randomized presses,
// each cycle compared against a history-window reference model of the debounced levels and pulses.
module tb_btn_conditioner;
  localparam int D    = 4;
  localparam int RD   = 20;
  localparam int RP   = 8;
  localparam int MAXC = 4096;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  btn_conditioner_if bus_if();

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int       vectors     = 0;
  int       miscompares = 0;
  int       k           = 0;
  bit [4:0] raw_h [MAXC];
  bit       rst_h [MAXC];
  bit [4:0] m_lvl;
  bit [4:0] m_pls;
  int       last_chg [5];
  int       rise_at  [5];

  function automatic bit synced(int j, int ch);
    if (j < 2) return 1'b0;
    if (rst_h[j-1] || rst_h[j-2]) return 1'b0;
    return raw_h[j-2][ch];
  endfunction

  function automatic logic [4:0] dut_pulses();
    return {bus_if.out_selected, bus_if.out_btn_right, bus_if.out_btn_left,
            bus_if.out_btn_down, bus_if.out_btn_up};
  endfunction

  // Level flips once the synchronized sample has disagreed with it for D whole cycles
  // since the last flip or reset; pulses on the rise and at RD + n*RP cycles after it.
  task automatic model_update();
    bit ok;
    int age;
    if (rst_h[k-1]) begin
      m_lvl = '0;
      m_pls = '0;
      for (int ch = 0; ch < 5; ch++) begin
        last_chg[ch] = k;
        rise_at[ch]  = -1;
      end
    end else begin
      for (int ch = 0; ch < 5; ch++) begin
        ok = 1'b1;
        for (int j = k - D; j < k; j++)
          if (j < last_chg[ch] || synced(j, ch) == m_lvl[ch]) ok = 1'b0;
        if (ok) begin
          m_lvl[ch]    = ~m_lvl[ch];
          last_chg[ch] = k;
          if (m_lvl[ch]) rise_at[ch] = k;
        end
        age = k - rise_at[ch];
        m_pls[ch] = m_lvl[ch] &&
                    (age == 0 || (REP_EN && ch != 4 && age >= RD && (age - RD) % RP == 0));
      end
    end
  endtask

  task automatic set_pins(input bit [4:0] prs, input bit r);
    rst = r;
    {bus_if.in_selected, bus_if.in_btn_right, bus_if.in_btn_left,
     bus_if.in_btn_down, bus_if.in_btn_up} = ~prs;
    raw_h[k] = prs;
    rst_h[k] = r;
  endtask

  task automatic advance(input bit [4:0] prs, input bit r);
    @(posedge clk);
    k++;
    if (k >= MAXC) begin
      $display("FAIL cycle_budget: reached cycle %0d, limit %0d", k, MAXC);
      $fatal(1);
    end
    model_update();
    #1 set_pins(prs, r);
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) advance(5'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      advance(5'($urandom), 1'b1);
      vectors++;
      if ({dut_pulses(), bus_if.btn_level} !== 10'd0) begin
        miscompares++;
        $display("FAIL reset_state cycle %0d: pulses/level %b/%b, required 00000/00000",
                 k, dut_pulses(), bus_if.btn_level);
      end
    end
    settle(10);
  endtask

  task automatic test_single_press();
    for (int i = 0; i < 24; i++) begin
      advance((i >= 10) ? 5'b00001 : 5'b0, 1'b0);
      vectors++;
      if (bus_if.out_btn_up !== (i == 16) || bus_if.btn_level[0] !== (i >= 16)) begin
        miscompares++;
        $display("FAIL single_press rel %0d: out_btn_up=%b level0=%b, required %b %b",
                 i, bus_if.out_btn_up, bus_if.btn_level[0], i == 16, i >= 16);
      end
      vectors++;
      if ({dut_pulses(), bus_if.btn_level} !== {m_pls, m_lvl}) begin
        miscompares++;
        $display("FAIL model_single_press cycle %0d: %b/%b, required %b/%b",
                 k, dut_pulses(), bus_if.btn_level, m_pls, m_lvl);
      end
    end
    settle(12);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 40; i++) begin
      advance(((i / 2) % 2 == 0) ? 5'b10000 : 5'b0, 1'b0);
      vectors++;
      if (bus_if.out_selected !== 1'b0 || bus_if.btn_level[4] !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce rel %0d: out_selected=%b level4=%b, required 0 0",
                 i, bus_if.out_selected, bus_if.btn_level[4]);
      end
    end
    settle(12);
  endtask

  task automatic test_hold_repeat();
    bit [63:0] left_mask = '0;
    left_mask[6] = 1'b1;
    if (REP_EN) begin
      left_mask[26] = 1'b1; left_mask[34] = 1'b1; left_mask[42] = 1'b1;
      left_mask[50] = 1'b1; left_mask[58] = 1'b1;
    end
    for (int i = 0; i < 60; i++) begin
      advance(5'b10100, 1'b0);
      vectors++;
      if (bus_if.out_btn_left !== left_mask[i] || bus_if.out_selected !== (i == 6)) begin
        miscompares++;
        $display("FAIL hold_repeat rel %0d: left=%b sel=%b, required %b %b",
                 i, bus_if.out_btn_left, bus_if.out_selected, left_mask[i], i == 6);
      end
      vectors++;
      if ({dut_pulses(), bus_if.btn_level} !== {m_pls, m_lvl}) begin
        miscompares++;
        $display("FAIL model_hold_repeat cycle %0d: %b/%b, required %b/%b",
                 k, dut_pulses(), bus_if.btn_level, m_pls, m_lvl);
      end
    end
    settle(12);
  endtask

  task automatic test_reset_mid_press();
    for (int i = 0; i < 20; i++) begin
      advance(5'b00010, (i == 4 || i == 5));
      vectors++;
      if (bus_if.out_btn_down !== (i == 12) || bus_if.btn_level[1] !== (i >= 12)) begin
        miscompares++;
        $display("FAIL reset_mid_press rel %0d: out_btn_down=%b level1=%b, required %b %b",
                 i, bus_if.out_btn_down, bus_if.btn_level[1], i == 12, i >= 12);
      end
    end
    settle(12);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 24; i++) begin
      advance((i >= 9 && i <= 11) ? 5'b0 : 5'b00011, 1'b0);
      vectors++;
      if ({bus_if.out_btn_down, bus_if.out_btn_up} !== ((i == 6) ? 2'b11 : 2'b00) ||
          bus_if.btn_level[1:0] !== ((i >= 6) ? 2'b11 : 2'b00)) begin
        miscompares++;
        $display("FAIL simultaneous rel %0d: down/up pulses=%b%b level=%b, required %b %b",
                 i, bus_if.out_btn_down, bus_if.out_btn_up, bus_if.btn_level[1:0],
                 (i == 6) ? 2'b11 : 2'b00, (i >= 6) ? 2'b11 : 2'b00);
      end
    end
    settle(12);
  endtask

  task automatic test_random();
    int       remain [5];
    bit [4:0] cur = 5'($urandom);
    bit       r;
    for (int ch = 0; ch < 5; ch++) remain[ch] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < 5; ch++) begin
        if (remain[ch] == 0) begin
          cur[ch]    = ~cur[ch];
          remain[ch] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, D - 1))
                                                   : int'($urandom_range(D, 70));
        end
        remain[ch]--;
      end
      r = ($urandom_range(0, 199) == 0);
      advance(cur, r);
      vectors++;
      if ({dut_pulses(), bus_if.btn_level} !== {m_pls, m_lvl}) begin
        miscompares++;
        $display("FAIL model_random cycle %0d: %b/%b, required %b/%b",
                 k, dut_pulses(), bus_if.btn_level, m_pls, m_lvl);
      end
    end
  endtask

  initial begin
    set_pins(5'($urandom), 1'b1);
    test_reset();
    test_single_press();
    test_bounce();
    test_hold_repeat();
    test_reset_mid_press();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
